// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one unified memory port between the instruction-fetch and data buses
module mem_bus_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iIReq,
  input  logic [ADDR_W-1:0]     iIAddress,
  output logic                  oIAck,
  output logic [DATA_W-1:0]     oIReadData,
  output logic                  oIStall,
  input  logic                  iDReq,
  input  logic                  iDWrite,
  input  logic [DATA_W/8-1:0]   iDByteEnable,
  input  logic [ADDR_W-1:0]     iDAddress,
  input  logic [DATA_W-1:0]     iDWriteData,
  output logic                  oDAck,
  output logic [DATA_W-1:0]     oDReadData,
  output logic                  oDStall,
  output logic                  oMemReadEnable,
  output logic                  oMemWriteEnable,
  output logic [DATA_W/8-1:0]   oMemByteEnable,
  output logic [ADDR_W-1:0]     oMemAddress,
  output logic [DATA_W-1:0]     oMemWriteData,
  input  logic [DATA_W-1:0]     iMemReadData,
  output logic                  oBusy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [3:0] CNT_TOP = 4'(MEM_LATENCY - 1);
  logic [0:0] state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [3:0] count_q, count_d;
  logic [DATA_W-1:0] iread_q, iread_d, dread_q, dread_d;
  logic access, fin, ack_i, ack_d, d_load, grant, winner, mem_i, mem_d;
  assign access = state_q == ACCESS;
  assign fin = access && count_q == 4'd0;
  assign ack_i = fin && owner_q == OWN_I;
  assign ack_d = fin && owner_q == OWN_D;
  assign d_load = ack_d && !iDWrite;
  assign mem_i = access && owner_q == OWN_I;
  assign mem_d = access && owner_q == OWN_D;
  // Arbitration: in IDLE the non-last winner takes ties; in the final ACCESS cycle only the non-owner may chain in
  always_comb begin
    grant = access ? (fin && (owner_q == OWN_I ? iDReq : iIReq)) : (iIReq || iDReq);
    winner = access ? ~owner_q : ((iIReq && iDReq) ? ~last_q : iDReq);
    state_d = (grant || (access && !fin)) ? ACCESS : IDLE;
    owner_d = grant ? winner : owner_q;
    last_d = grant ? winner : last_q;
    count_d = grant ? CNT_TOP : ((access && !fin) ? count_q - 4'd1 : count_q);
    iread_d = ack_i ? iMemReadData : iread_q;
    dread_d = d_load ? iMemReadData : dread_q;
  end
  // Memory drive and requester responses, all derived from the current owner
  always_comb begin
    oIAck = ack_i;
    oDAck = ack_d;
    oIReadData = ack_i ? iMemReadData : iread_q;
    oDReadData = d_load ? iMemReadData : dread_q;
    oIStall = iIReq && !ack_i;
    oDStall = iDReq && !ack_d;
    oMemReadEnable = mem_i || (mem_d && !iDWrite);
    oMemWriteEnable = mem_d && iDWrite;
    oMemByteEnable = mem_i ? '1 : (mem_d ? iDByteEnable : '0);
    oMemAddress = mem_i ? iIAddress : (mem_d ? iDAddress : '0);
    oMemWriteData = mem_d ? iDWriteData : '0;
    oBusy = access;
  end
  // State registers; reset aborts any access in flight and favours I on the first tie
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q <= OWN_D;
      count_q <= 4'd0;
      iread_q <= '0;
      dread_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      count_q <= count_d;
      iread_q <= iread_d;
      dread_q <= dread_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table, directed and randomized checks of mem_bus_arbiter at latencies 1..3
module tb_mem_bus_arbiter;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;
  logic iIReq = 1'b0, iDReq = 1'b0, iDWrite = 1'b0;
  logic [3:0] iDByteEnable = '0;
  logic [31:0] iIAddress = '0, iDAddress = '0, iDWriteData = '0, iMemReadData;
  logic ia [3], da [3], ist [3], dst [3], re [3], we [3], bz [3];
  logic [31:0] ird [3], drd [3], ma [3], mwd [3];
  logic [3:0] mbe [3];
  int sel = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_arbiter #(.MEM_LATENCY(g + 1), .ADDR_W(32), .DATA_W(32)) u_dut (
      .iCLK(iCLK), .iRST(iRST),
      .iIReq(iIReq), .iIAddress(iIAddress), .oIAck(ia[g]), .oIReadData(ird[g]), .oIStall(ist[g]),
      .iDReq(iDReq), .iDWrite(iDWrite), .iDByteEnable(iDByteEnable), .iDAddress(iDAddress),
      .iDWriteData(iDWriteData), .oDAck(da[g]), .oDReadData(drd[g]), .oDStall(dst[g]),
      .oMemReadEnable(re[g]), .oMemWriteEnable(we[g]), .oMemByteEnable(mbe[g]),
      .oMemAddress(ma[g]), .oMemWriteData(mwd[g]), .iMemReadData(iMemReadData), .oBusy(bz[g])
    );
  end
  logic oIAck, oDAck, oIStall, oDStall, oMemReadEnable, oMemWriteEnable, oBusy;
  logic [31:0] oIReadData, oDReadData, oMemAddress, oMemWriteData;
  logic [3:0] oMemByteEnable;
  assign oIAck = ia[sel];
  assign oDAck = da[sel];
  assign oIStall = ist[sel];
  assign oDStall = dst[sel];
  assign oMemReadEnable = re[sel];
  assign oMemWriteEnable = we[sel];
  assign oBusy = bz[sel];
  assign oIReadData = ird[sel];
  assign oDReadData = drd[sel];
  assign oMemAddress = ma[sel];
  assign oMemWriteData = mwd[sel];
  assign oMemByteEnable = mbe[sel];

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  function automatic logic [7:0] idx(logic [31:0] a);
    return {a[28], a[22], a[7:2]};
  endfunction
  assign iMemReadData = mem[idx(oMemAddress)];

  int nchk = 0, npass = 0;
  int cyc, ack_at, lat;
  bit busy, own, last, last_ei, last_ed;
  logic [31:0] exp_ir, exp_dr;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h want %h (cycle %0d, latency %0d)", n, a, e, cyc, lat);
  endtask

  task automatic model_reset();
    busy = 0; own = 0; last = 1; cyc = 0; ack_at = 0;
    exp_ir = '0; exp_dr = '0; last_ei = 0; last_ed = 0;
  endtask

  // Samples at the falling edge, compares against the transaction schedule, then advances it
  task automatic check_cycle();
    bit fin, ei, ed;
    logic [31:0] w;
    @(negedge iCLK);
    fin = busy && cyc == ack_at;
    ei = fin && !own;
    ed = fin && own;
    if (ei) exp_ir = shadow[idx(iIAddress)];
    if (ed && !iDWrite) exp_dr = shadow[idx(iDAddress)];
    if (ed && iDWrite) begin
      w = shadow[idx(iDAddress)];
      for (int b = 0; b < 4; b++) if (iDByteEnable[b]) w[8*b +: 8] = iDWriteData[8*b +: 8];
      shadow[idx(iDAddress)] = w;
    end
    chk("iack", oIAck, ei);
    chk("dack", oDAck, ed);
    chk("iread", oIReadData, exp_ir);
    chk("dread", oDReadData, exp_dr);
    chk("istall", oIStall, iIReq && !ei);
    chk("dstall", oDStall, iDReq && !ed);
    chk("busy", oBusy, busy);
    chk("mem_re", oMemReadEnable, busy && (!own || !iDWrite));
    chk("mem_we", oMemWriteEnable, busy && own && iDWrite);
    chk("mem_addr", oMemAddress, busy ? (own ? iDAddress : iIAddress) : 32'h0);
    chk("mem_be", oMemByteEnable, busy ? (own ? iDByteEnable : 4'hf) : 4'h0);
    chk("mem_wdata", oMemWriteData, (busy && own) ? iDWriteData : 32'h0);
    if (oMemWriteEnable) begin
      w = mem[idx(oMemAddress)];
      for (int b = 0; b < 4; b++) if (oMemByteEnable[b]) w[8*b +: 8] = oMemWriteData[8*b +: 8];
      mem[idx(oMemAddress)] = w;
    end
    if (fin) begin
      if (own ? iIReq : iDReq) begin own = !own; last = own; ack_at = cyc + lat; end
      else busy = 0;
    end else if (!busy && (iIReq || iDReq)) begin
      own = (iIReq && iDReq) ? !last : iDReq;
      last = own; busy = 1; ack_at = cyc + lat;
    end
    last_ei = ei;
    last_ed = ed;
    cyc++;
  endtask

  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset(int s);
    iRST = 1; iIReq = 0; iDReq = 0; iDWrite = 0; iDByteEnable = 0;
    iIAddress = 0; iDAddress = 0; iDWriteData = 0;
    sel = s; lat = s + 1;
    @(negedge iCLK);
    chk("rst_busy", oBusy, 0);
    chk("rst_iread", oIReadData, 0);
    chk("rst_dread", oDReadData, 0);
    chk("rst_strobes", {oMemReadEnable, oMemWriteEnable, oIAck, oDAck}, 0);
    @(posedge iCLK);
    #1;
    iRST = 0;
    model_reset();
  endtask

  task automatic agent();
    if (!iIReq || last_ei) begin
      iIReq = $urandom_range(0, 9) < 6;
      iIAddress = 32'h0040_0000 | (32'($urandom_range(0, 63)) << 2);
    end
    if (!iDReq || last_ed) begin
      iDReq = $urandom_range(0, 9) < 6;
      iDWrite = $urandom_range(0, 1) == 1;
      iDByteEnable = 4'($urandom_range(0, 15));
      iDWriteData = $urandom;
      iDAddress = 32'h1001_0000 | (32'($urandom_range(16, 63)) << 2);
    end
  endtask

  typedef struct {
    bit i, d, w;
    bit ia, da, ist, dst, re, we, bz;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int cnt, first, prev;
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 32'hC0DE_0000 | k;
    mem[8'h40] = 32'h0000_0013;
    mem[8'h80] = 32'h1234_5678;
    mem[8'h81] = 32'h0000_0000;
    for (int k = 0; k < 256; k++) shadow[k] = mem[k];
    tbl[0] = '{1, 1, 0,  0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 0,  1, 0, 0, 1, 1, 0, 1};
    tbl[2] = '{1, 1, 0,  0, 1, 1, 0, 1, 0, 1};
    tbl[3] = '{1, 1, 0,  1, 0, 0, 1, 1, 0, 1};
    tbl[4] = '{1, 1, 0,  0, 1, 1, 0, 1, 0, 1};
    tbl[5] = '{1, 0, 0,  1, 0, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 1, 1,  0, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{0, 1, 1,  0, 1, 0, 0, 0, 1, 1};
    tbl[8] = '{0, 0, 0,  0, 0, 0, 0, 0, 0, 0};

    do_reset(0);
    iIAddress = 32'h0040_0010; iDAddress = 32'h1001_0040;
    iDByteEnable = 4'hf; iDWriteData = 32'h55AA_55AA;
    for (int r = 0; r < 9; r++) begin
      iIReq = tbl[r].i; iDReq = tbl[r].d; iDWrite = tbl[r].w;
      check_cycle();
      chk($sformatf("tbl%0d_ia", r), oIAck, tbl[r].ia);
      chk($sformatf("tbl%0d_da", r), oDAck, tbl[r].da);
      chk($sformatf("tbl%0d_istall", r), oIStall, tbl[r].ist);
      chk($sformatf("tbl%0d_dstall", r), oDStall, tbl[r].dst);
      chk($sformatf("tbl%0d_re", r), oMemReadEnable, tbl[r].re);
      chk($sformatf("tbl%0d_we", r), oMemWriteEnable, tbl[r].we);
      chk($sformatf("tbl%0d_busy", r), oBusy, tbl[r].bz);
      next_cycle();
    end

    do_reset(0);
    iIReq = 1; iIAddress = 32'h0040_0000;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) iIReq = 0;
      check_cycle();
      cnt += int'(oIStall);
      if (c == 1) begin
        chk("fetch_ack", oIAck, 1);
        chk("fetch_data", oIReadData, 32'h0000_0013);
      end
      next_cycle();
    end
    chk("fetch_stall_cycles", cnt, 1);
    chk("fetch_data_held", oIReadData, 32'h0000_0013);

    do_reset(2);
    iDReq = 1; iDWrite = 1; iDByteEnable = 4'b0011;
    iDWriteData = 32'hDEAD_BEEF; iDAddress = 32'h1001_0004;
    cnt = 0; first = -1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) iDWrite = 0;
      check_cycle();
      if (oMemWriteEnable && oMemByteEnable == 4'b0011) cnt++;
      if (oDAck && first < 0) first = c;
      if (c == 3) chk("write_dread_unchanged", oDReadData, 32'h0);
      if (c == 7) begin
        chk("readback_ack", oDAck, 1);
        chk("readback_data", oDReadData, 32'h0000_BEEF);
        iDReq = 0;
      end
      next_cycle();
    end
    chk("write_strobe_cycles", cnt, 3);
    chk("write_ack_cycle", first, 3);

    do_reset(1);
    iIReq = 1; iIAddress = 32'h0040_0020;
    cnt = 0; first = -1; prev = -1; ok = 1;
    for (int c = 0; c < 12; c++) begin
      check_cycle();
      if (!oBusy) cnt++;
      if (oIAck) begin
        if (first < 0) first = c;
        else if (c - prev != 3) ok = 0;
        prev = c;
      end
      next_cycle();
    end
    chk("lone_first_ack", first, 2);
    chk("lone_spacing", ok, 1);
    chk("lone_last_ack", prev, 11);
    chk("lone_idle_cycles", cnt, 4);

    do_reset(2);
    iDReq = 1; iDWrite = 1; iDByteEnable = 4'hf;
    iDWriteData = 32'hA5A5_0F0F; iDAddress = 32'h1001_0008;
    check_cycle(); next_cycle();
    check_cycle(); next_cycle();
    #2;
    iRST = 1;
    #1;
    chk("abort_we", oMemWriteEnable, 0);
    chk("abort_re", oMemReadEnable, 0);
    chk("abort_dack", oDAck, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_addr", oMemAddress, 0);
    chk("abort_be", oMemByteEnable, 0);
    chk("abort_wdata", oMemWriteData, 0);
    iIReq = 1; iIAddress = 32'h0040_0030;
    @(posedge iCLK);
    #1;
    iRST = 0;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      if (last_ei) iIReq = 0;
      if (last_ed) iDReq = 0;
      check_cycle();
      if (c == 1) begin
        chk("after_abort_i_first", oMemReadEnable, 1);
        chk("after_abort_addr", oMemAddress, 32'h0040_0030);
      end
      next_cycle();
    end

    do_reset(0);
    iDReq = 1; iDWrite = 0; iDAddress = 32'h1001_0000;
    check_cycle(); next_cycle();
    check_cycle();
    chk("load_data", oDReadData, 32'h1234_5678);
    next_cycle();
    iDReq = 0; iIReq = 1; iIAddress = 32'h0040_0004;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) iIReq = 0;
      check_cycle();
      chk("load_held", oDReadData, 32'h1234_5678);
      next_cycle();
    end

    for (int s = 0; s < 3; s++) begin
      do_reset(s);
      for (int c = 0; c < 300; c++) begin
        agent();
        check_cycle();
        next_cycle();
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
